// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT frame controller: FSM state encoding and
// default frame/timeout/stability constants.
package fft_ctrl_pkg;

  localparam int NSAMPLES_DEF      = 1024;
  localparam int TIMEOUT_DEF       = 4096;
  localparam int STABLE_FRAMES_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_WAIT_OUT,
    ST_WAIT_PEAK,
    ST_HOLDOFF
  } fft_state_e;

endpackage

// File: rtl/fft_pitch_stabilizer.sv
// Pitch stability filter: fire only after STABLE_FRAMES consecutive firing
// frames whose peak bins stay within +/-1 of the previous accepted bin.
module fft_pitch_stabilizer
  import fft_ctrl_pkg::*;
#(
  parameter int K             = 10,
  parameter int STABLE_FRAMES = STABLE_FRAMES_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         accept,
  input  logic         abort,
  input  logic [K-1:0] peak_k,
  input  logic         fire_in,
  output logic         fire
);

  localparam int RW = $clog2(STABLE_FRAMES + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_FRAMES);

  logic [RW-1:0] run, run_nxt;
  logic [K-1:0]  prev_k;
  logic [K:0]    pk_x, prev_x;
  logic          near;

  // Widened by one bit so bins 0 and NSamples-1 are not treated as neighbours.
  always_comb begin
    pk_x    = {1'b0, peak_k};
    prev_x  = {1'b0, prev_k};
    near    = (pk_x == prev_x) || (pk_x == prev_x + 1'b1) || (prev_x == pk_x + 1'b1);
    run_nxt = run;
    if (!fire_in)
      run_nxt = '0;
    else if (run == '0 || !near)
      run_nxt = RW'(1);
    else if (run != RUN_MAX)
      run_nxt = run + 1'b1;
    fire = fire_in && (run_nxt == RUN_MAX);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      run    <= '0;
      prev_k <= '0;
    end else if (abort) begin
      run    <= '0;
    end else if (accept) begin
      run    <= run_nxt;
      prev_k <= peak_k;
    end
  end

endmodule

// File: rtl/fft_frame_controller.sv
// Frame sequencer between input buffer, FFT core and peak detector.
// Optional pitch stability filter enabled by macro PITCH_STABLE_EN.
//
// state        | meaning
// ST_IDLE      | waiting for frame_ready
// ST_FEED      | streaming NSamples buffer reads into the FFT
// ST_WAIT_OUT  | counting FFT output bins, timeout armed
// ST_WAIT_PEAK | waiting for the peak detector result, timeout armed
// ST_HOLDOFF   | idle gap between frames
module fft_frame_controller
  import fft_ctrl_pkg::*;
#(
  parameter int NSamples      = NSAMPLES_DEF,
  parameter int W             = 16,
  parameter int HOLDOFF       = 0,
  parameter int TIMEOUT       = TIMEOUT_DEF,
  parameter int STABLE_FRAMES = STABLE_FRAMES_DEF,
  localparam int K            = $clog2(NSamples)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         frame_ready,
  output logic         frame_ack,
  output logic         rd_en,
  output logic [K-1:0] rd_addr,
  input  logic [W-1:0] rd_data,
  output logic         fft_di_en,
  output logic [W-1:0] fft_di_re,
  input  logic         fft_do_en,
  input  logic         peak_valid_in,
  input  logic [K-1:0] peak_k_in,
  input  logic         fire_in,
  output logic [K-1:0] pitch_out,
  output logic         pitch_valid,
  output logic         fire_out,
  output logic         busy,
  output logic         timeout_err,
  output logic [15:0]  frame_count
);

  localparam int CW = K + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(HOLDOFF + 2);
  localparam logic [CW-1:0] DO_FULL   = CW'(NSamples);
  localparam logic [K-1:0]  ADDR_LAST = K'(NSamples - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  fft_state_e    state, state_nxt;
  logic [K-1:0]  rd_cnt;
  logic [CW-1:0] do_cnt, do_cnt_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [HW-1:0] hold_cnt;
  logic          di_en_q;
  logic          do_hit, tmo_hit, accept, fire_nxt;

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    tmo_hit    = (state == ST_WAIT_OUT || state == ST_WAIT_PEAK) && (tmo_cnt == TMO_LAST);
    // A bin strobe landing on the timeout cycle is dropped.
    do_hit     = fft_do_en && !tmo_hit && (do_cnt < DO_FULL) &&
                 (state == ST_FEED || state == ST_WAIT_OUT);
    do_cnt_nxt = do_cnt + {{K{1'b0}}, do_hit};
    case (state)
      ST_IDLE:      if (frame_ready) state_nxt = ST_FEED;
      ST_FEED:      if (rd_cnt == ADDR_LAST) state_nxt = ST_WAIT_OUT;
      ST_WAIT_OUT: begin
        if (tmo_hit)                    state_nxt = ST_IDLE;
        else if (do_cnt_nxt == DO_FULL) state_nxt = ST_WAIT_PEAK;
      end
      ST_WAIT_PEAK: begin
        if (tmo_hit) begin
          state_nxt = ST_IDLE;
        end else if (peak_valid_in) begin
          accept    = 1'b1;
          state_nxt = (HOLDOFF > 0) ? ST_HOLDOFF : ST_IDLE;
        end
      end
      ST_HOLDOFF:   if (hold_cnt == '0) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rd_cnt      <= '0;
      do_cnt      <= '0;
      tmo_cnt     <= '0;
      hold_cnt    <= '0;
      di_en_q     <= 1'b0;
      pitch_out   <= '0;
      pitch_valid <= 1'b0;
      fire_out    <= 1'b0;
      timeout_err <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_nxt;
      di_en_q     <= rd_en;
      pitch_valid <= accept;
      rd_cnt      <= (state == ST_FEED) ? rd_cnt + 1'b1 : '0;

      if (state == ST_IDLE && state_nxt == ST_FEED)
        do_cnt <= '0;
      else
        do_cnt <= do_cnt_nxt;

      // Any state change restarts the timeout window.
      if (state_nxt != state)
        tmo_cnt <= '0;
      else if (state == ST_WAIT_OUT || state == ST_WAIT_PEAK)
        tmo_cnt <= tmo_cnt + 1'b1;

      if (accept)
        hold_cnt <= HOLD_LOAD;
      else if (state == ST_HOLDOFF && hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;

      if (accept) begin
        pitch_out   <= peak_k_in;
        fire_out    <= fire_nxt;
        frame_count <= frame_count + 16'd1;
      end

      if (tmo_hit)
        timeout_err <= 1'b1;
    end
  end

`ifdef PITCH_STABLE_EN
  fft_pitch_stabilizer #(
    .K             (K),
    .STABLE_FRAMES (STABLE_FRAMES)
  ) u_stab (
    .clk     (clk),
    .reset   (reset),
    .accept  (accept),
    .abort   (tmo_hit),
    .peak_k  (peak_k_in),
    .fire_in (fire_in),
    .fire    (fire_nxt)
  );
`else
  localparam int unused_stable_frames = STABLE_FRAMES;
  assign fire_nxt = fire_in;
`endif

  assign rd_en     = (state == ST_FEED);
  assign rd_addr   = rd_cnt;
  assign frame_ack = rd_en && (rd_cnt == ADDR_LAST);
  assign fft_di_en = di_en_q;
  assign fft_di_re = di_en_q ? rd_data : '0;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_fft_frame_controller.sv
// Self-checking bench for fft_frame_controller (NSamples=16, HOLDOFF=8,
// TIMEOUT=64); stability expectations follow PITCH_STABLE_EN when defined.
module tb_fft_frame_controller;

  localparam int N   = 16;
  localparam int K   = 4;
  localparam int W   = 16;
  localparam int HO  = 8;
  localparam int TMO = 64;
  localparam int SF  = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         frame_ready;
  logic         frame_ack;
  logic         rd_en;
  logic [K-1:0] rd_addr;
  logic [W-1:0] rd_data = '0;
  logic         fft_di_en;
  logic [W-1:0] fft_di_re;
  logic         fft_do_en;
  logic         peak_valid_in;
  logic [K-1:0] peak_k_in;
  logic         fire_in;
  logic [K-1:0] pitch_out;
  logic         pitch_valid;
  logic         fire_out;
  logic         busy;
  logic         timeout_err;
  logic [15:0]  frame_count;

  fft_frame_controller #(
    .NSamples(N), .W(W), .HOLDOFF(HO), .TIMEOUT(TMO), .STABLE_FRAMES(SF)
  ) dut (
    .clk(clk), .reset(reset), .frame_ready(frame_ready), .frame_ack(frame_ack),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .fft_di_en(fft_di_en), .fft_di_re(fft_di_re), .fft_do_en(fft_do_en),
    .peak_valid_in(peak_valid_in), .peak_k_in(peak_k_in), .fire_in(fire_in),
    .pitch_out(pitch_out), .pitch_valid(pitch_valid), .fire_out(fire_out),
    .busy(busy), .timeout_err(timeout_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read input buffer
  logic [W-1:0] mem [N];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int n_tests = 0;
  int n_fail  = 0;
  int steps;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted-frame history, outputs derived from it
  typedef struct { int k; bit f; } acc_t;
  acc_t        hist[$];
  logic [K-1:0] m_pitch;
  logic        m_fire;
  int          m_count;
  logic        m_tmo;

  function automatic bit model_fire(input bit fi);
`ifdef PITCH_STABLE_EN
    int n;
    n = hist.size();
    if (!fi || n < SF) return 1'b0;
    for (int j = n - SF; j < n; j++) begin
      if (!hist[j].f) return 1'b0;
      if (j > n - SF && (hist[j].k - hist[j-1].k > 1 || hist[j-1].k - hist[j].k > 1)) return 1'b0;
    end
    return 1'b1;
`else
    return fi;
`endif
  endfunction

  task automatic model_accept(input int k, input bit fi);
    acc_t a;
    a.k = k; a.f = fi;
    hist.push_back(a);
    m_pitch = K'(k);
    m_fire  = model_fire(fi);
    m_count = (m_count + 1) % 65536;
  endtask

  task automatic model_timeout();
    m_tmo = 1'b1;
    hist.delete();
  endtask

  task automatic model_reset();
    hist.delete();
    m_pitch = '0; m_fire = 1'b0; m_count = 0; m_tmo = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    fft_do_en     = 1'b0;
    peak_valid_in = 1'b0;
    steps++;
  endtask

  task automatic do_frame(input int n_do, input logic [K-1:0] pk, input logic fi, input int pdly,
                          input logic [K-1:0] e_pitch, input logic e_fire, input int e_count,
                          input logic e_tmo, input bit hold);
    int busy_cyc;
    for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
    frame_ready = 1'b1;
    steps = 0;
    while (!rd_en && steps < 20) step();
    check("feed_start", rd_en, 1);
    for (int i = 0; i < N; i++) begin
      check("rd_en", rd_en, 1);
      check("rd_addr", rd_addr, i);
      check("frame_ack", frame_ack, (i == N - 1));
      check("di_en", fft_di_en, (i > 0));
      if (i > 0) check("di_re", fft_di_re, mem[i-1]);
      if (i == N - 1) frame_ready = 1'b0;
      step();
    end
    check("rd_en_off", rd_en, 0);
    check("di_en_last", fft_di_en, 1);
    check("di_re_last", fft_di_re, mem[N-1]);
    // Stray peak while still waiting for bins must be ignored
    peak_valid_in = 1'b1; peak_k_in = pk + 4'd8; fire_in = ~fi;
    steps = 0;
    for (int p = 0; p < n_do; p++) begin
      repeat ($urandom_range(0, 2)) step();
      fft_do_en = 1'b1;
      step();
    end
    if (n_do < N) begin
      while (busy && steps < 200) step();
      check("tmo_cycles", steps, TMO);
      check("timeout_err", timeout_err, 1);
      check("tmo_pitch", pitch_out, e_pitch);
      check("tmo_fire", fire_out, e_fire);
      check("tmo_count", frame_count, e_count);
    end else begin
      check("wait_peak_busy", busy, 1);
      repeat (pdly) step();
      peak_valid_in = 1'b1; peak_k_in = pk; fire_in = fi;
      step();
      check("pitch_valid", pitch_valid, 1);
      check("pitch_out", pitch_out, e_pitch);
      check("fire_out", fire_out, e_fire);
      check("frame_count", frame_count, e_count);
      check("timeout_err_keep", timeout_err, e_tmo);
      peak_valid_in = 1'b1; peak_k_in = pk + 4'd3; fire_in = ~fi;
      if (hold) frame_ready = 1'b1;
      busy_cyc = 0;
      while (busy && busy_cyc < 40) begin
        busy_cyc++;
        step();
        if (busy_cyc == 1) check("pitch_valid_pulse", pitch_valid, 0);
      end
      check("holdoff_cycles", busy_cyc, HO);
      check("pitch_hold", pitch_out, e_pitch);
      check("count_hold", frame_count, e_count);
      if (hold) begin
        step();
        check("feed_after_holdoff", rd_en, 1);
      end
    end
  endtask

  typedef struct {
    int           n_do;
    logic [K-1:0] pk;
    logic         fi;
    logic [K-1:0] e_pitch;
    logic         e_fire_plain;
    logic         e_fire_stab;
    int           e_count;
    logic         e_tmo;
    bit           hold;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vec_t v;
    logic ef;
    int   t, nd;
    bit   fi_r, hold_r;

    vecs[0] = '{16, 4'd5, 1'b1, 4'd5, 1'b1, 1'b0, 1, 1'b0, 1'b1};
    vecs[1] = '{16, 4'd6, 1'b1, 4'd6, 1'b1, 1'b0, 2, 1'b0, 1'b0};
    vecs[2] = '{16, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 3, 1'b0, 1'b0};
    vecs[3] = '{16, 4'd9, 1'b1, 4'd9, 1'b1, 1'b0, 4, 1'b0, 1'b0};
    vecs[4] = '{10, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0, 4, 1'b1, 1'b0};
    vecs[5] = '{16, 4'd3, 1'b0, 4'd3, 1'b0, 1'b0, 5, 1'b1, 1'b0};

    reset = 1'b0; frame_ready = 1'b0; fft_do_en = 1'b0;
    peak_valid_in = 1'b0; peak_k_in = '0; fire_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_pitch", pitch_out, 0);
    check("rst_count", frame_count, 0);
    check("rst_tmo", timeout_err, 0);
    reset = 1'b1;
    step();

    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.n_do < N) model_timeout();
      else            model_accept(v.pk, v.fi);
`ifdef PITCH_STABLE_EN
      ef = v.e_fire_stab;
`else
      ef = v.e_fire_plain;
`endif
      do_frame(v.n_do, v.pk, v.fi, $urandom_range(0, 5), v.e_pitch, ef, v.e_count, v.e_tmo, v.hold);
    end

    for (int r = 0; r < 12; r++) begin
      nd = ($urandom_range(0, 4) == 0) ? $urandom_range(1, N - 1) : N;
      if ($urandom_range(0, 3) != 0) begin
        t = int'(m_pitch) + $urandom_range(0, 2) - 1;
        if (t < 0) t = 0;
        if (t > N - 1) t = N - 1;
      end else begin
        t = $urandom_range(0, N - 1);
      end
      fi_r   = ($urandom_range(0, 5) != 0);
      hold_r = (r < 11) && ($urandom_range(0, 1) == 1);
      if (nd < N) model_timeout();
      else        model_accept(t, fi_r);
      do_frame(nd, K'(t), fi_r, $urandom_range(0, 10), m_pitch, m_fire, m_count, m_tmo, hold_r);
    end

    // Reset in the middle of FEED
    for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
    frame_ready = 1'b1;
    steps = 0;
    while (!rd_en && steps < 20) step();
    while (rd_en && rd_addr != 4'd7 && steps < 40) begin
      check("ack_before_reset", frame_ack, 0);
      step();
    end
    check("reached_addr7", rd_addr, 7);
    reset = 1'b0; frame_ready = 1'b0;
    step();
    model_reset();
    check("mr_rd_en", rd_en, 0);
    check("mr_rd_addr", rd_addr, 0);
    check("mr_frame_ack", frame_ack, 0);
    check("mr_di_en", fft_di_en, 0);
    check("mr_di_re", fft_di_re, 0);
    check("mr_pitch", pitch_out, 0);
    check("mr_pitch_valid", pitch_valid, 0);
    check("mr_fire", fire_out, 0);
    check("mr_busy", busy, 0);
    check("mr_tmo", timeout_err, 0);
    check("mr_count", frame_count, 0);
    reset = 1'b1;
    step();
    check("post_reset_ack", frame_ack, 0);
    check("post_reset_busy", busy, 0);
    model_accept(4, 1'b1);
    do_frame(N, 4'd4, 1'b1, 2, m_pitch, m_fire, m_count, m_tmo, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
